cpu_sram_arbiter: RTL and testbench
===================================

// Module: cpu_sram_arbiter
// PURPOSE
//  Shares one sram-like memory port between the instruction-fetch requester (inst_*)
//  and the data-access requester (data_*) driven by the EXE stage.
//  Sits between the CPU pipeline and the downstream AXI bridge.
//  Data side has fixed priority. An anti-starvation counter forces an inst grant
//  after STARVE_LIMIT consecutive contested data grants.
//  Exactly one transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  STARVE_LIMIT  4   consecutive contested data grants before inst is forced; legal range 1..15
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  inst_req       in   1       inst request; held until inst_addr_ok
//  inst_wr        in   1       1 = write
//  inst_size      in   2       0 = byte, 1 = half, 2 = word
//  inst_addr      in   ADDR_W  byte address
//  inst_wdata     in   DATA_W  write data
//  inst_addr_ok   out  1       request accepted
//  inst_data_ok   out  1       transaction complete; inst_rdata valid
//  inst_rdata     out  DATA_W  read data
//  data_req .. data_rdata      same set of ports as inst_*, for the data side
//  mem_req        out  1       downstream request
//  mem_wr         out  1       downstream write flag
//  mem_size       out  2       downstream size
//  mem_addr       out  ADDR_W  downstream address
//  mem_wdata      out  DATA_W  downstream write data
//  mem_addr_ok    in   1       downstream accepted the request
//  mem_data_ok    in   1       downstream completed the transaction
//  mem_rdata      in   DATA_W  downstream read data
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT. Registers: owner (0 = inst, 1 = data), latched wr/size/addr/wdata,
//  starve_cnt (4 bit).
//  Reset: state = IDLE, starve_cnt = 0, owner = 0. All *_addr_ok, *_data_ok and mem_req are 0.
//   mem_wr/size/addr/wdata and *_rdata are 0.
//  IDLE, arbitration happens at the clock edge:
//   - data_req only: grant data.
//   - inst_req only: grant inst.
//   - both asserted: grant inst if starve_cnt == STARVE_LIMIT, otherwise grant data.
//   - On a grant: latch owner and the granted wr/size/addr/wdata, then go to REQ.
//   - starve_cnt: +1 on a data grant while inst_req = 1 (saturates at STARVE_LIMIT);
//     cleared on any inst grant; holds otherwise.
//  REQ:
//   - mem_req = 1; mem_* driven from the latched fields.
//   - Owner's addr_ok = mem_addr_ok (combinational, same cycle); the other side's addr_ok = 0.
//   - mem_addr_ok = 1 -> WAIT; otherwise stay in REQ, fields unchanged.
//  WAIT:
//   - mem_req = 0.
//   - Owner's data_ok = mem_data_ok; owner's rdata = mem_rdata (combinational).
//   - mem_data_ok = 1 -> IDLE.
//  The non-owner side never sees addr_ok or data_ok.
//  rdata on the non-owner side is 0. Owner rdata is 0 except while data_ok = 1.
//  Latency: a req first seen in IDLE in cycle N drives mem_req in N+1.
//   With addr_ok in N+1 and data_ok in N+2, IDLE is re-entered at N+3: 3-cycle minimum turnaround.
//  Ignored conditions (no state change): mem_data_ok in IDLE or REQ; mem_addr_ok outside REQ.
//  A request not yet granted simply waits; requesters must hold req and fields stable until addr_ok.
//  Writes complete the same way as reads: data_ok is returned and rdata carries a don't-care value.
//  Reset mid-transaction aborts it with no ok pulse. Any mem_data_ok arriving after reset is ignored
//  (state is IDLE).
// TESTING
//  1 Inst-only read: inst_req, addr 0xBFC00000; mem_addr_ok at once, mem_data_ok next cycle,
//    rdata 0x3C1D0000 -> mem_addr 0xBFC00000, inst_addr_ok then inst_data_ok with rdata 0x3C1D0000,
//    3-cycle turnaround.
//  2 Simultaneous inst and data req in IDLE -> data granted first (mem_addr = data_addr),
//    inst served next, starve_cnt = 1 after the first grant.
//  3 Both reqs held continuously, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,...;
//    starve_cnt returns to 0 on the inst grant.
//  4 Downstream holds mem_addr_ok low for 5 cycles -> mem_req and mem_addr stay stable,
//    no ok to either side; the other side stays unserved.
//  5 Data sw (size 2, addr 0x1FAF0000, wdata 0xDEADBEEF) -> mem_wr = 1 with those exact fields;
//    data_data_ok pulses for exactly 1 cycle; inst side stays idle.
//  6 Assert reset while in WAIT, then pulse mem_data_ok after reset -> no data_ok, state IDLE,
//    all outputs 0.

Source files
------------

// File: rtl/cpu_sram_arbiter.sv
// Arbitrates one sram-like memory port between the instruction-fetch and data requesters.
// Data side has fixed priority, and a starvation counter forces an inst grant when both sides keep requesting.
module cpu_sram_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        starve_q, starve_d;
   logic              grant_data, grant_inst;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      // inst wins a contested cycle only once the data side has used up its run
      grant_data = data_req && !(inst_req && (starve_q == LIMIT));
      grant_inst = inst_req && !grant_data;

      case (state_q)
         IDLE: begin
            if (grant_data) begin
               owner_d = 1'b1;
               wr_d    = data_wr;
               size_d  = data_size;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               state_d = REQ;
               if (inst_req) begin
                  starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
               end
            end else if (grant_inst) begin
               owner_d  = 1'b0;
               wr_d     = inst_wr;
               size_d   = inst_size;
               addr_d   = inst_addr;
               wdata_d  = inst_wdata;
               state_d  = REQ;
               starve_d = '0;
            end
         end
         REQ: begin
            if (mem_addr_ok) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_data_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      inst_rdata   = '0;
      data_rdata   = '0;

      if (state_q == REQ) begin
         mem_req      = 1'b1;
         mem_wr       = wr_q;
         mem_size     = size_q;
         mem_addr     = addr_q;
         mem_wdata    = wdata_q;
         inst_addr_ok = !owner_q && mem_addr_ok;
         data_addr_ok =  owner_q && mem_addr_ok;
      end

      if (state_q == WAIT && mem_data_ok) begin
         if (owner_q) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
         end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: grant order, starvation break, stalls, writes and reset abort.
module tb_cpu_sram_arbiter;

   localparam logic [31:0] IADDR = 32'hBFC0_0010;
   localparam logic [31:0] DADDR = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Entered with the arbiter in REQ; serves one transaction and leaves it back in IDLE.
   task automatic xact(input string tag, input logic own, input logic [31:0] eaddr,
                       input logic [31:0] rd, input logic drop);
      mem_addr_ok = 1'b1;
      #1;
      chk({tag, ":mem_req"}, 64'(mem_req), 64'd1);
      chk({tag, ":mem_addr"}, 64'(mem_addr), 64'(eaddr));
      chk({tag, ":own_addr_ok"}, 64'(own ? data_addr_ok : inst_addr_ok), 64'd1);
      chk({tag, ":oth_addr_ok"}, 64'(own ? inst_addr_ok : data_addr_ok), 64'd0);
      tick;
      mem_addr_ok = 1'b0;
      if (drop) begin
         if (own) data_req = 1'b0;
         else     inst_req = 1'b0;
      end
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      #1;
      chk({tag, ":wait_mem_req"}, 64'(mem_req), 64'd0);
      chk({tag, ":own_data_ok"}, 64'(own ? data_data_ok : inst_data_ok), 64'd1);
      chk({tag, ":own_rdata"}, 64'(own ? data_rdata : inst_rdata), 64'(rd));
      chk({tag, ":oth_data_ok"}, 64'(own ? inst_data_ok : data_data_ok), 64'd0);
      chk({tag, ":oth_rdata"}, 64'(own ? inst_rdata : data_rdata), 64'd0);
      tick;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic own_seq [6];
      logic [3:0] starve_seq [6];
      own_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      starve_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

      reset = 1'b1;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
      tick;
      tick;
      chk("rst:mem_req", 64'(mem_req), 64'd0);
      chk("rst:mem_addr", 64'(mem_addr), 64'd0);
      chk("rst:inst_addr_ok", 64'(inst_addr_ok), 64'd0);
      chk("rst:data_addr_ok", 64'(data_addr_ok), 64'd0);
      chk("rst:starve", 64'(dut.starve_q), 64'd0);
      reset = 1'b0;

      // 1: inst-only read
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      #1;
      chk("t1:idle_mem_req", 64'(mem_req), 64'd0);
      tick;
      xact("t1", 1'b0, 32'hBFC0_0000, 32'h3C1D_0000, 1'b1);

      // 2: simultaneous request right at re-entry to IDLE
      inst_req = 1'b1; inst_addr = IADDR;
      data_req = 1'b1; data_addr = DADDR;
      #1;
      chk("t2:idle_mem_req", 64'(mem_req), 64'd0);
      tick;
      chk("t2:starve_after_d", 64'(dut.starve_q), 64'd1);
      xact("t2d", 1'b1, DADDR, 32'h1111_1111, 1'b1);
      tick;
      chk("t2:starve_after_i", 64'(dut.starve_q), 64'd0);
      xact("t2i", 1'b0, IADDR, 32'h2222_2222, 1'b0);

      // 3: both held continuously -> D,D,D,D,I,D
      data_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk($sformatf("t3:starve%0d", i), 64'(dut.starve_q), 64'(starve_seq[i]));
         xact($sformatf("t3g%0d", i), own_seq[i], own_seq[i] ? DADDR : IADDR, 32'hA0 + i, 1'b0);
      end

      // 4: downstream stalls addr_ok for 5 cycles; stray data_ok in REQ is ignored
      tick;
      for (int i = 0; i < 5; i++) begin
         mem_data_ok = (i == 2);
         #1;
         chk($sformatf("t4:mem_req%0d", i), 64'(mem_req), 64'd1);
         chk($sformatf("t4:mem_addr%0d", i), 64'(mem_addr), 64'(DADDR));
         chk($sformatf("t4:oks%0d", i),
             64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
         tick;
      end
      mem_data_ok = 1'b0;
      xact("t4d", 1'b1, DADDR, 32'h4444_4444, 1'b1);
      tick;
      xact("t4i", 1'b0, IADDR, 32'h5555_5555, 1'b1);

      // 5: data store
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
      data_addr = 32'h1FAF_0000; data_wdata = 32'hDEAD_BEEF;
      tick;
      mem_addr_ok = 1'b1;
      #1;
      chk("t5:mem_wr", 64'(mem_wr), 64'd1);
      chk("t5:mem_size", 64'(mem_size), 64'd2);
      chk("t5:mem_addr", 64'(mem_addr), 64'h1FAF_0000);
      chk("t5:mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("t5:data_addr_ok", 64'(data_addr_ok), 64'd1);
      chk("t5:inst_addr_ok", 64'(inst_addr_ok), 64'd0);
      tick;
      data_req = 1'b0; data_wr = 1'b0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
      #1;
      chk("t5:data_data_ok", 64'(data_data_ok), 64'd1);
      chk("t5:inst_data_ok", 64'(inst_data_ok), 64'd0);
      tick;
      mem_data_ok = 1'b0;
      #1;
      chk("t5:data_ok_one_cycle", 64'(data_data_ok), 64'd0);
      chk("t5:idle_mem_req", 64'(mem_req), 64'd0);

      // 6: reset during WAIT, then a late mem_data_ok
      data_req = 1'b1; data_addr = 32'h0000_2000;
      tick;
      mem_addr_ok = 1'b1;
      tick;
      mem_addr_ok = 1'b0; data_req = 1'b0;
      #1;
      chk("t6:wait_mem_req", 64'(mem_req), 64'd0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
      #1;
      chk("t6:data_data_ok", 64'(data_data_ok), 64'd0);
      chk("t6:data_rdata", 64'(data_rdata), 64'd0);
      chk("t6:mem_req", 64'(mem_req), 64'd0);
      chk("t6:mem_addr", 64'(mem_addr), 64'd0);
      chk("t6:state", 64'(dut.state_q), 64'd0);
      tick;
      mem_data_ok = 1'b0;
      #1;
      chk("t6:state_after", 64'(dut.state_q), 64'd0);
      chk("t6:mem_req_after", 64'(mem_req), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
